sprite_blitter: RTL and testbench

Parametrised monochrome-sprite blitter for the 160x120 VGA framebuffer path. On a `start` pulse it sweeps a SPR_W x SPR_H sprite from one of NUM_SPRITES 1-bit synchronous ROMs, maps each ROM bit to a foreground or background colour, clips against the screen edge, and emits one pixel write per cycle to `vga_adapter` (`x`, `y`, `colour`, `plot`). It replaces the fixed full-screen sweep with positioned, sized, selectable sprites and a start/busy/done handshake to the game controller.

---
 rtl/sprite_blitter.sv | 177 +++++++++++++++++
 tb/tb_sprite_blitter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_blitter.sv
// Positioned monochrome sprite blitter: sweeps a SPR_W x SPR_H 1-bit ROM and emits one clipped pixel per cycle.
// Define BLIT_TRANSPARENT_EN to leave ROM-bit-1 pixels unplotted instead of filling them with bg_colour.
module sprite_blitter #(
    parameter int SCREEN_W    = 160,
    parameter int SCREEN_H    = 120,
    parameter int SPR_W       = 160,
    parameter int SPR_H       = 120,
    parameter int NUM_SPRITES = 3,
    parameter int X_BITS      = 8,
    parameter int Y_BITS      = 7,
    parameter int ADDR_BITS   = 15,
    parameter int COLOUR_BITS = 3,
    localparam int SEL_BITS   = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic                   start,
    input  logic [SEL_BITS-1:0]    sprite_sel,
    input  logic [X_BITS-1:0]      x0,
    input  logic [Y_BITS-1:0]      y0,
    input  logic [COLOUR_BITS-1:0] fg_colour,
    input  logic [COLOUR_BITS-1:0] bg_colour,
    output logic                   busy,
    output logic                   done,
    output logic [SEL_BITS-1:0]    rom_sel,
    output logic [ADDR_BITS-1:0]   rom_addr,
    input  logic                   rom_q,
    output logic [X_BITS-1:0]      x,
    output logic [Y_BITS-1:0]      y,
    output logic [COLOUR_BITS-1:0] colour,
    output logic                   plot
);

    localparam int COL_BITS = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int ROW_BITS = (SPR_H > 1) ? $clog2(SPR_H) : 1;

    localparam logic [ADDR_BITS-1:0] LAST_ADDR    = ADDR_BITS'(SPR_W * SPR_H - 1);
    localparam logic [COL_BITS-1:0]  LAST_COL     = COL_BITS'(SPR_W - 1);
    localparam logic [X_BITS:0]      SCREEN_W_EXT = (X_BITS + 1)'(SCREEN_W);
    localparam logic [Y_BITS:0]      SCREEN_H_EXT = (Y_BITS + 1)'(SCREEN_H);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAW,
        S_FLUSH,
        S_DONE
    } state_e;

    state_e                 state_q;
    logic                   flush_q;
    logic                   busy_q;
    logic                   done_q;
    logic [SEL_BITS-1:0]    sel_q;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [COL_BITS-1:0]    col_q;
    logic [ROW_BITS-1:0]    row_q;
    logic [X_BITS-1:0]      x0_q;
    logic [Y_BITS-1:0]      y0_q;
    logic [COLOUR_BITS-1:0] fg_q;
    logic [COLOUR_BITS-1:0] bg_q;

    // Stage 1 holds the coordinates of the address whose data is now on rom_q.
    logic                   s1_valid_q;
    logic [COL_BITS-1:0]    s1_col_q;
    logic [ROW_BITS-1:0]    s1_row_q;

    logic [X_BITS-1:0]      x_q;
    logic [Y_BITS-1:0]      y_q;
    logic [COLOUR_BITS-1:0] colour_q;
    logic                   plot_q;

    logic [X_BITS:0]        x_sum_d;
    logic [Y_BITS:0]        y_sum_d;
    logic [COLOUR_BITS-1:0] colour_d;
    logic                   plot_d;

    // NOTE: every sequential assignment uses <= so all registers update from the same pre-edge values.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= S_IDLE;
            flush_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sel_q   <= '0;
            addr_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        sel_q   <= (int'(sprite_sel) < NUM_SPRITES) ? sprite_sel : '0;
                        x0_q    <= x0;
                        y0_q    <= y0;
                        fg_q    <= fg_colour;
                        bg_q    <= bg_colour;
                        addr_q  <= '0;
                        col_q   <= '0;
                        row_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_DRAW;
                    end
                end
                S_DRAW: begin
                    if (addr_q == LAST_ADDR) begin
                        flush_q <= 1'b0;
                        state_q <= S_FLUSH;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                        if (col_q == LAST_COL) begin
                            col_q <= '0;
                            row_q <= row_q + 1'b1;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    if (flush_q) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        flush_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // NOTE: every output of this block gets a value before any condition, so no latch can be inferred.
    always_comb begin
        x_sum_d  = {1'b0, x0_q} + (X_BITS + 1)'(s1_col_q);
        y_sum_d  = {1'b0, y0_q} + (Y_BITS + 1)'(s1_row_q);
        colour_d = rom_q ? bg_q : fg_q;
        plot_d   = s1_valid_q && (x_sum_d < SCREEN_W_EXT) && (y_sum_d < SCREEN_H_EXT);
`ifdef BLIT_TRANSPARENT_EN
        plot_d   = plot_d && !rom_q;
`endif
    end

    // Clipped pixels still occupy their slot so blit duration never depends on position.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            colour_q   <= '0;
            plot_q     <= 1'b0;
        end else begin
            s1_valid_q <= (state_q == S_DRAW);
            s1_col_q   <= col_q;
            s1_row_q   <= row_q;
            plot_q     <= plot_d;
            if (s1_valid_q) begin
                x_q      <= x_sum_d[X_BITS-1:0];
                y_q      <= y_sum_d[Y_BITS-1:0];
                colour_q <= colour_d;
            end
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rom_sel  = sel_q;
    assign rom_addr = addr_q;
    assign x        = x_q;
    assign y        = y_q;
    assign colour   = colour_q;
    assign plot     = plot_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter with a 4x2 sprite; expectations follow BLIT_TRANSPARENT_EN if defined.
`timescale 1ns/1ps
module tb_sprite_blitter;

    localparam int SPR_W = 4;
    localparam int SPR_H = 2;
    localparam int N     = SPR_W * SPR_H;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] sprite_sel;
    logic [7:0] x0;
    logic [6:0] y0;
    logic [2:0] fg_colour;
    logic [2:0] bg_colour;
    logic       busy;
    logic       done;
    logic [1:0] rom_sel;
    logic [14:0] rom_addr;
    logic       rom_q = 1'b0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;

    always #5 clk = ~clk;

    sprite_blitter #(
        .SCREEN_W(160), .SCREEN_H(120), .SPR_W(SPR_W), .SPR_H(SPR_H),
        .NUM_SPRITES(3), .X_BITS(8), .Y_BITS(7), .ADDR_BITS(15), .COLOUR_BITS(3)
    ) dut (
        .CLOCK_50(clk), .reset(reset), .start(start), .sprite_sel(sprite_sel),
        .x0(x0), .y0(y0), .fg_colour(fg_colour), .bg_colour(bg_colour),
        .busy(busy), .done(done), .rom_sel(rom_sel), .rom_addr(rom_addr), .rom_q(rom_q),
        .x(x), .y(y), .colour(colour), .plot(plot)
    );

    // Synchronous ROM bank; entry 3 is a poison image that no legal selection may reach.
    logic [7:0] rom_bits [4];
    always @(posedge clk) rom_q <= rom_bits[rom_sel][rom_addr[2:0]];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int x;
        int y;
        int colour;
    } pix_t;

    pix_t exp_q[$];
    int   done_q[$];
    int   compared   = 0;
    int   mismatched = 0;
    bit   mon_en     = 1'b0;
    int   exp_sel    = 0;
    pix_t mon_e;
    int   mon_d;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (plot !== 1'b0) begin
                if (exp_q.size() == 0) begin
                    check("plot_unexpected", plot, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("plot_cycle", cyc, mon_e.cyc);
                    check("plot_x", x, mon_e.x);
                    check("plot_y", y, mon_e.y);
                    check("plot_colour", colour, mon_e.colour);
                end
            end
            if (done !== 1'b0) begin
                if (done_q.size() == 0) begin
                    check("done_unexpected", done, 0);
                end else begin
                    mon_d = done_q.pop_front();
                    check("done_cycle", cyc, mon_d);
                    check("busy_in_done", busy, 0);
                end
            end
            if (busy === 1'b1) check("rom_sel_stable", rom_sel, exp_sel);
        end
    end

    task automatic push_blit(input int t0, input logic [7:0] x0v, input logic [6:0] y0v,
                             input logic [2:0] fg, input logic [2:0] bg, input logic [7:0] pat,
                             input int nslots, input bit with_done);
        for (int k = 0; k < nslots; k++) begin
            int xs = int'(x0v) + k % SPR_W;
            int ys = int'(y0v) + k / SPR_W;
            bit on = (xs < 160) && (ys < 120);
`ifdef BLIT_TRANSPARENT_EN
            if (pat[k]) on = 1'b0;
`endif
            if (on) exp_q.push_back('{t0 + 2 + k, xs, ys, int'(pat[k] ? bg : fg)});
        end
        if (with_done) done_q.push_back(t0 + N + 2);
    endtask

    task automatic do_start(input logic [1:0] sel, input logic [7:0] x0v, input logic [6:0] y0v,
                            input logic [2:0] fg, input logic [2:0] bg, output int t0);
        @(negedge clk);
        sprite_sel = sel;
        x0         = x0v;
        y0         = y0v;
        fg_colour  = fg;
        bg_colour  = bg;
        start      = 1'b1;
        t0         = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_blit(input logic [1:0] sel, input logic [7:0] x0v, input logic [6:0] y0v,
                            input logic [2:0] fg, input logic [2:0] bg, input logic [7:0] pat,
                            input int sel_exp);
        int t0;
        exp_sel = sel_exp;
        do_start(sel, x0v, y0v, fg, bg, t0);
        push_blit(t0, x0v, y0v, fg, bg, pat, N, 1'b1);
        check("busy_after_start", busy, 1);
        check("rom_addr_first", rom_addr, 0);
        repeat (N + 1) @(negedge clk);
        check("busy_last_cycle", busy, 1);
        check("done_early", done, 0);
        @(negedge clk);
        check("busy_dropped", busy, 0);
        check("done_pulse", done, 1);
        @(negedge clk);
        check("done_one_cycle", done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t0;
        reset      = 1'b1;
        start      = 1'b0;
        sprite_sel = '0;
        x0         = '0;
        y0         = '0;
        fg_colour  = '0;
        bg_colour  = '0;
        rom_bits[0] = 8'hFF;
        rom_bits[1] = 8'h00;
        rom_bits[2] = 8'hFF;
        rom_bits[3] = 8'hFF;

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_plot", plot, 0);
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_colour", colour, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_rom_sel", rom_sel, 0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Opaque all-ink sprite fully on screen, then clipped at right and bottom edges.
        run_blit(2'd1, 8'd10, 7'd20, 3'b101, 3'b011, 8'h00, 1);
        run_blit(2'd1, 8'd158, 7'd20, 3'b101, 3'b011, 8'h00, 1);
        run_blit(2'd1, 8'd50, 7'd119, 3'b110, 3'b001, 8'h00, 1);

        // Alternating pattern: addr 0 is background.
        rom_bits[2] = 8'h55;
        run_blit(2'd2, 8'd100, 7'd50, 3'b010, 3'b111, 8'h55, 2);

        // Out-of-range selection must fall back to sprite 0.
        rom_bits[0] = 8'h00;
        run_blit(2'd3, 8'd20, 7'd30, 3'b001, 3'b110, 8'h00, 0);

        // Reset in the fourth cycle of a blit: only the first two pixels make it out.
        exp_sel = 1;
        do_start(2'd1, 8'd10, 7'd20, 3'b100, 3'b011, t0);
        push_blit(t0, 8'd10, 7'd20, 3'b100, 3'b011, 8'h00, 2, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_plot", plot, 0);
        check("midrst_rom_addr", rom_addr, 0);
        check("midrst_done", done, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_idle_plot", plot, 0);
        run_blit(2'd1, 8'd10, 7'd20, 3'b100, 3'b011, 8'h00, 1);

        // start held through the blit and DONE: second blit starts on the IDLE cycle.
        exp_sel = 1;
        @(negedge clk);
        sprite_sel = 2'd1;
        x0         = 8'd0;
        y0         = 7'd0;
        fg_colour  = 3'b011;
        bg_colour  = 3'b100;
        start      = 1'b1;
        t0         = cyc + 1;
        push_blit(t0, 8'd0, 7'd0, 3'b011, 3'b100, 8'h00, N, 1'b1);
        push_blit(t0 + N + 4, 8'd0, 7'd0, 3'b011, 3'b100, 8'h00, N, 1'b1);
        repeat (N + 4) @(negedge clk);
        check("held_idle_gap_busy", busy, 0);
        @(negedge clk);
        check("held_restart_busy", busy, 1);
        check("held_restart_addr", rom_addr, 0);
        start = 1'b0;
        repeat (N + 6) @(negedge clk);
        check("held_single_second", busy, 0);

        repeat (5) @(negedge clk);
        check("plots_outstanding", exp_q.size(), 0);
        check("dones_outstanding", done_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
